ts_tx_sched: RTL and testbench
==============================

// Module: ts_tx_sched
// PURPOSE
//   Transmit scheduler directly downstream of the metadata buffer (mb). Chooses one of the
//   four metadata queues from per-queue empty flags, gate-control open bits and a q2
//   token-bucket shaper. Issues a single-cycle read enable to the chosen queue, captures
//   the 8-bit metadata mb returns, and holds off until the output port reports the frame is sent.
// PARAMETERS
//   TOKEN_W    16     width of the q2 token counter (bytes)
//   RATE       1      tokens added per clk to the q2 bucket
//   BURST      3036   bucket ceiling in bytes (<= 2^TOKEN_W-1)
//   MD_TMO     4      clocks allowed between read enable and mb metadata strobe
// PORTS
//   clk                 in   1   system clock
//   rst_n               in   1   synchronous reset, active low
//   in_ts_fifo_empty    in   4   mb queue empty flags, bit i = queue i
//   in_ts_gate_open     in   4   GC gate state, 1 = queue i may transmit
//   in_ts_pkt_len       in   11  byte length of head-of-line q2 frame
//   in_ts_md            in   8   metadata returned by mb
//   in_ts_md_wr         in   1   in_ts_md valid strobe
//   in_ts_tx_done       in   1   1-clk pulse: output port finished current frame
//   out_ts_q0_rden      out  1   read pulse to mb queue 0 (q1..q3 likewise)
//   out_ts_q1_rden      out  1
//   out_ts_q2_rden      out  1
//   out_ts_q3_rden      out  1
//   out_ts_md           out  8   metadata forwarded to packet fetch
//   out_ts_md_wr        out  1   out_ts_md valid, 1 clk
//   out_ts_busy         out  1   1 while a frame is in flight (state != IDLE)
//   out_ts_md_err       out  1   sticky: metadata timeout seen; cleared only by reset
// BEHAVIOUR
//   Reset: one clock, synchronous, active low. All outputs 0, state IDLE, tokens = BURST, timeout count 0.
//   Eligibility (IDLE only): elig[i] = ~empty[i] & gate_open[i]; q2 additionally needs tokens >= pkt_len.
//   Strict priority q0 > q1 > q2 > q3. Exactly one rden is high per cycle, for one clk only.
//   FSM:
//     IDLE    : any elig -> assert rden of winner (registered, out next clk) -> RDEN
//     RDEN    : rden pulse visible; rdens return 0 -> WAIT_MD
//     WAIT_MD : on in_ts_md_wr: out_ts_md <= in_ts_md, out_ts_md_wr <= 1 (1-clk latency) -> WAIT_TX
//               no strobe within MD_TMO clks of RDEN: set out_ts_md_err, -> IDLE (no tx_done wait)
//     WAIT_TX : wait for in_ts_tx_done -> IDLE; next grant can occur in the IDLE cycle that follows
//   in_ts_tx_done outside WAIT_TX and in_ts_md_wr outside WAIT_MD are ignored.
//   Token bucket, every clk: t' = min(tokens + RATE, BURST), saturating at BURST.
//     On the IDLE cycle q2 is granted: tokens <= t' - pkt_len. No underflow: the eligibility check uses current tokens.
//     Refill continues in all states, including while q2 is in flight.
//   Gate closing after a grant has no effect on the frame in flight; no preemption.
//   Empty queue with gate open: not eligible. All gates closed: stay IDLE, outputs 0.
//   Reset asserted in any state: return to IDLE on the next edge; any pending rden/md_wr drops.
// TESTING
//   1. q0,q3 non-empty, all gates open -> q0_rden pulse 1 clk; md 0x5A returned -> out_ts_md=0x5A, md_wr 1 clk.
//   2. q0 non-empty, gate_open=4'b1110, q1 non-empty -> q1 granted; q0 is never read while its gate stays closed.
//   3. tokens=BURST=3036, q2 pkt_len=1500 twice back-to-back (tx_done 2 clk after md) -> 2nd grant at tokens~1536+refill;
//      a 3rd frame of 1500 stalls until tokens>=1500, with q3 served meanwhile if non-empty.
//   4. rden issued, no in_ts_md_wr for 4 clks -> out_ts_md_err=1, busy=0, next eligible queue granted.
//   5. tx_done pulsed in IDLE and WAIT_MD -> no state change; busy stays 1 until tx_done arrives in WAIT_TX.
//   6. rst_n=0 for 1 clk during WAIT_TX -> next clk busy=0, all rden=0, err=0, tokens=BURST.

Source files
------------

// File: rtl/ts_tx_sched.sv
// Transmit scheduler: picks one of four metadata-buffer queues by strict priority, with a
// token-bucket shaper on q2, then tracks the frame from read enable through metadata to tx_done.
module ts_tx_sched #(
    parameter int TOKEN_W = 16,
    parameter int RATE    = 1,
    parameter int BURST   = 3036,
    parameter int MD_TMO  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_ts_fifo_empty,
    input  logic [3:0]  in_ts_gate_open,
    input  logic [10:0] in_ts_pkt_len,
    input  logic [7:0]  in_ts_md,
    input  logic        in_ts_md_wr,
    input  logic        in_ts_tx_done,
    output logic        out_ts_q0_rden,
    output logic        out_ts_q1_rden,
    output logic        out_ts_q2_rden,
    output logic        out_ts_q3_rden,
    output logic [7:0]  out_ts_md,
    output logic        out_ts_md_wr,
    output logic        out_ts_busy,
    output logic        out_ts_md_err
);

    localparam int CNT_W = $clog2(MD_TMO + 1);

    typedef enum logic [1:0] {
        IDLE,
        RDEN,
        WAIT_MD,
        WAIT_TX
    } state_t;

    state_t             r_state;
    logic [3:0]         r_rden;
    logic [7:0]         r_md;
    logic               r_md_wr;
    logic               r_md_err;
    logic [TOKEN_W-1:0] r_tokens;
    logic [CNT_W-1:0]   r_tmo_cnt;

    logic [TOKEN_W:0]   w_tok_sum;
    logic [TOKEN_W-1:0] w_tok_refill;
    logic [TOKEN_W-1:0] w_pkt_len;
    logic [3:0]         w_elig;
    logic [3:0]         w_grant;

    // One extra bit on the sum so the saturation compare cannot wrap.
    assign w_tok_sum    = {1'b0, r_tokens} + (TOKEN_W + 1)'(RATE);
    assign w_tok_refill = (w_tok_sum >= (TOKEN_W + 1)'(BURST)) ? TOKEN_W'(BURST)
                                                               : w_tok_sum[TOKEN_W-1:0];
    assign w_pkt_len    = TOKEN_W'(in_ts_pkt_len);

    always_comb begin
        w_elig    = ~in_ts_fifo_empty & in_ts_gate_open;
        w_elig[2] = w_elig[2] & (r_tokens >= w_pkt_len);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_grant = 4'b0000;
        if (w_elig[0])      w_grant = 4'b0001;
        else if (w_elig[1]) w_grant = 4'b0010;
        else if (w_elig[2]) w_grant = 4'b0100;
        else if (w_elig[3]) w_grant = 4'b1000;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rden    <= '0;
            r_md      <= '0;
            r_md_wr   <= 1'b0;
            r_md_err  <= 1'b0;
            r_tokens  <= TOKEN_W'(BURST);
            r_tmo_cnt <= '0;
        end else begin
            r_rden   <= '0;
            r_md_wr  <= 1'b0;
            r_tokens <= w_tok_refill;
            unique case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_rden  <= w_grant;
                        r_state <= RDEN;
                        // Eligibility already guaranteed tokens >= len, so this cannot underflow.
                        if (w_grant[2]) r_tokens <= w_tok_refill - w_pkt_len;
                    end
                end
                RDEN: begin
                    r_tmo_cnt <= '0;
                    r_state   <= WAIT_MD;
                end
                WAIT_MD: begin
                    if (in_ts_md_wr) begin
                        r_md    <= in_ts_md;
                        r_md_wr <= 1'b1;
                        r_state <= WAIT_TX;
                    end else if (r_tmo_cnt == CNT_W'(MD_TMO - 1)) begin
                        r_md_err <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (in_ts_tx_done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_ts_q0_rden = r_rden[0];
    assign out_ts_q1_rden = r_rden[1];
    assign out_ts_q2_rden = r_rden[2];
    assign out_ts_q3_rden = r_rden[3];
    assign out_ts_md      = r_md;
    assign out_ts_md_wr   = r_md_wr;
    assign out_ts_busy    = (r_state != IDLE);
    assign out_ts_md_err  = r_md_err;

endmodule

// File: tb/tb_ts_tx_sched.sv
// Self-checking bench for ts_tx_sched: directed scenarios plus randomized frames against a
// transaction-level model of priority selection, the q2 token bucket and the sticky error flag.
module tb_ts_tx_sched;

    localparam int BURST  = 3036;
    localparam int MD_TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_empty;
    logic [3:0]  in_gate;
    logic [10:0] in_len;
    logic [7:0]  in_md;
    logic        in_md_wr;
    logic        in_tx_done;
    logic        q0_rden, q1_rden, q2_rden, q3_rden;
    logic [7:0]  out_md;
    logic        out_md_wr;
    logic        busy;
    logic        md_err;
    logic [3:0]  rden;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int m_tok;
    int m_stamp;
    bit m_err;

    ts_tx_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_ts_fifo_empty (in_empty),
        .in_ts_gate_open  (in_gate),
        .in_ts_pkt_len    (in_len),
        .in_ts_md         (in_md),
        .in_ts_md_wr      (in_md_wr),
        .in_ts_tx_done    (in_tx_done),
        .out_ts_q0_rden   (q0_rden),
        .out_ts_q1_rden   (q1_rden),
        .out_ts_q2_rden   (q2_rden),
        .out_ts_q3_rden   (q3_rden),
        .out_ts_md        (out_md),
        .out_ts_md_wr     (out_md_wr),
        .out_ts_busy      (busy),
        .out_ts_md_err    (md_err)
    );

    assign rden = {q3_rden, q2_rden, q1_rden, q0_rden};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bucket level seen by the scheduler at edge e, given no q2 grant since m_stamp.
    function automatic int tok_at(input int e);
        int t;
        t = m_tok + (e - m_stamp);
        return (t > BURST) ? BURST : t;
    endfunction

    function automatic int pick(input logic [3:0] empty, input logic [3:0] gate,
                                input int len, input int tok);
        for (int i = 0; i < 4; i++)
            if (!empty[i] && gate[i] && (i != 2 || tok >= len)) return i;
        return -1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_tok   = BURST;
        m_stamp = cyc + 1;
        m_err   = 1'b0;
    endtask

    // One frame from the IDLE decision to tx_done. md_delay >= MD_TMO means metadata never
    // arrives; tx_delay < 0 leaves the frame parked in WAIT_TX.
    task automatic run_frame(input logic [3:0] empty, input logic [3:0] gate, input int len,
                             input logic [7:0] md, input int md_delay, input int tx_delay,
                             input bit close_gate, input bit noise, output int won);
        int waited = 0;
        int t;
        int nostrobe;
        won = -1;
        in_empty = empty;
        in_gate  = gate;
        in_len   = 11'(len);
        forever begin
            won = pick(empty, gate, len, tok_at(cyc + 1));
            if (won >= 0) break;
            tick();
            n_cmp++;
            if (rden !== 4'b0 || busy !== 1'b0) begin
                n_mis++;
                $display("FAIL stall_idle: got rden=%b busy=%b, expected rden=0000 busy=0", rden, busy);
            end
            waited++;
            if (waited > 5000) begin
                n_mis++;
                $display("FAIL stall_budget: no eligible queue after %0d cycles, expected one", waited);
                in_empty = 4'hF;
                return;
            end
        end
        if (won == 2) begin
            t = tok_at(cyc + 1) + 1;
            if (t > BURST) t = BURST;
            m_tok   = t - len;
            m_stamp = cyc + 2;
        end
        tick();
        n_cmp++;
        if (rden !== 4'(1 << won) || busy !== 1'b1 || md_err !== m_err) begin
            n_mis++;
            $display("FAIL grant: got rden=%b busy=%b err=%b, expected rden=%b busy=1 err=%b",
                     rden, busy, md_err, 4'(1 << won), m_err);
        end
        if (close_gate) in_gate = 4'b0;
        tick();
        n_cmp++;
        if (rden !== 4'b0 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL rden_pulse: got rden=%b busy=%b, expected rden=0000 busy=1", rden, busy);
        end
        nostrobe = (md_delay < MD_TMO) ? md_delay : MD_TMO;
        for (int k = 0; k < nostrobe; k++) begin
            in_tx_done = noise;
            tick();
            in_tx_done = 1'b0;
            if (k == MD_TMO - 1) m_err = 1'b1;
            n_cmp++;
            if (busy !== (k != MD_TMO - 1) || md_err !== m_err || out_md_wr !== 1'b0 || rden !== 4'b0) begin
                n_mis++;
                $display("FAIL wait_md: got busy=%b err=%b md_wr=%b rden=%b, expected busy=%b err=%b md_wr=0 rden=0000",
                         busy, md_err, out_md_wr, rden, (k != MD_TMO - 1), m_err);
            end
        end
        if (md_delay >= MD_TMO) begin
            in_empty = 4'hF;
            return;
        end
        in_md_wr = 1'b1;
        in_md    = md;
        tick();
        in_md_wr = 1'b0;
        in_md    = 8'($urandom);
        n_cmp++;
        if (out_md_wr !== 1'b1 || out_md !== md || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL md_capture: got md=%h md_wr=%b busy=%b, expected md=%h md_wr=1 busy=1",
                     out_md, out_md_wr, busy, md);
        end
        if (tx_delay < 0) return;
        for (int k = 0; k < tx_delay; k++) begin
            in_md_wr = noise;
            tick();
            in_md_wr = 1'b0;
            n_cmp++;
            if (out_md_wr !== 1'b0 || out_md !== md || busy !== 1'b1) begin
                n_mis++;
                $display("FAIL wait_tx: got md=%h md_wr=%b busy=%b, expected md=%h md_wr=0 busy=1",
                         out_md, out_md_wr, busy, md);
            end
        end
        in_tx_done = 1'b1;
        tick();
        in_tx_done = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || rden !== 4'b0 || out_md_wr !== 1'b0) begin
            n_mis++;
            $display("FAIL tx_done: got busy=%b rden=%b md_wr=%b, expected busy=0 rden=0000 md_wr=0",
                     busy, rden, out_md_wr);
        end
        in_empty = 4'hF;
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        n_cmp++;
        if (rden !== 4'b0 || out_md !== 8'h00 || out_md_wr !== 1'b0 || busy !== 1'b0 || md_err !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_state: got rden=%b md=%h md_wr=%b busy=%b err=%b, expected all 0",
                     rden, out_md, out_md_wr, busy, md_err);
        end
    endtask

    task automatic test_priority();
        int w;
        run_frame(4'b0110, 4'hF, 100, 8'h5A, 1, 2, 1'b0, 1'b0, w);
        n_cmp++;
        if (w != 0) begin
            n_mis++;
            $display("FAIL prio_q0: model winner %0d, expected 0", w);
        end
        for (int i = 0; i < 3; i++)
            run_frame(4'b1100, 4'b1110, 100, 8'(8'h10 + i), 0, 1, 1'b0, 1'b0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        run_frame(4'b1011, 4'hF, 1500, 8'hA1, 0, 1, 1'b0, 1'b0, w);
        run_frame(4'b1011, 4'hF, 1500, 8'hA2, 0, 1, 1'b0, 1'b0, w);
        for (int i = 0; i < 3; i++)
            run_frame(4'b0011, 4'hF, 1500, 8'(8'hB0 + i), 0, 1, 1'b1, 1'b0, w);
        run_frame(4'b1011, 4'hF, 1500, 8'hA3, 0, 1, 1'b0, 1'b0, w);
    endtask

    task automatic test_timeout();
        int w;
        run_frame(4'b1101, 4'hF, 64, 8'h00, MD_TMO, 0, 1'b0, 1'b0, w);
        run_frame(4'b1101, 4'hF, 64, 8'h3C, 2, 1, 1'b0, 1'b0, w);
    endtask

    task automatic test_tx_done_ignored();
        int w;
        in_empty   = 4'hF;
        in_tx_done = 1'b1;
        in_md_wr   = 1'b1;
        tick();
        in_tx_done = 1'b0;
        in_md_wr   = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_md_wr !== 1'b0 || rden !== 4'b0) begin
            n_mis++;
            $display("FAIL idle_ignore: got busy=%b md_wr=%b rden=%b, expected 0 0 0000", busy, out_md_wr, rden);
        end
        run_frame(4'b0111, 4'b1000, 200, 8'hC3, 3, 3, 1'b0, 1'b1, w);
    endtask

    task automatic test_reset_mid_frame();
        int w;
        run_frame(4'b1101, 4'hF, 10, 8'hE7, 0, -1, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_tok   = BURST;
        m_stamp = cyc + 1;
        m_err   = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || rden !== 4'b0 || md_err !== 1'b0 || out_md_wr !== 1'b0 || out_md !== 8'h00) begin
            n_mis++;
            $display("FAIL reset_mid: got busy=%b rden=%b err=%b md_wr=%b md=%h, expected all 0",
                     busy, rden, md_err, out_md_wr, out_md);
        end
        run_frame(4'b1011, 4'hF, 2047, 8'h71, 0, 0, 1'b0, 1'b0, w);
        run_frame(4'b1011, 4'hF, 1000, 8'h72, 0, 0, 1'b0, 1'b0, w);
    endtask

    task automatic test_random();
        logic [3:0] e;
        logic [3:0] g;
        int w;
        for (int i = 0; i < 30; i++) begin
            do begin
                e = 4'($urandom);
                g = 4'($urandom);
            end while ((~e & g) == 4'b0);
            run_frame(e, g, int'($urandom_range(1, 1024)), 8'($urandom),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), w);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_empty   = 4'hF;
        in_gate    = 4'h0;
        in_len     = '0;
        in_md      = '0;
        in_md_wr   = 1'b0;
        in_tx_done = 1'b0;
        m_tok      = BURST;
        m_stamp    = 0;
        m_err      = 1'b0;
        tick();
        test_reset();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_tx_done_ignored();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
